perf_sample_checker: RTL and testbench

Consumer end of the perfcounter sample stream in the simulation bench: accepts (event, count) samples over a valid/ready handshake, checks each sample for legality, and drives the bench's `sim_report`, `sim_done` and `sim_success` outputs. The CI harness watches these outputs to grade the perfcounter run. It ends the run either after a fixed number of samples or when the stream goes idle for too long.

---
 rtl/perf_sample_checker.sv | 138 +++++++++++++
 tb/tb_perf_sample_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_sample_checker.sv
// Consumer end of the perfcounter sample stream: checks each (event, count) sample
// and reports the run outcome on sim_report / sim_done / sim_success.
module perf_sample_checker #(
  parameter int EVENT_WIDTH      = 8,
  parameter int COUNT_WIDTH      = 32,
  parameter int EXPECTED_SAMPLES = 16,
  parameter int TIMEOUT          = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [EVENT_WIDTH-1:0] s_event,
  input  logic [COUNT_WIDTH-1:0] s_count,
  input  logic                   s_last,
  output logic [15:0]            sample_count,
  output logic [15:0]            error_count,
  output logic [31:0]            sim_report,
  output logic                   sim_done,
  output logic                   sim_success
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SUMMARY = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [15:0] EXPECTED_C   = 16'(EXPECTED_SAMPLES);
  localparam logic [31:0] TIMEOUT_M1_C = 32'(TIMEOUT - 1);

  state_t                 state_r;
  logic                   s_ready_r;
  logic [15:0]            sample_count_r;
  logic [15:0]            error_count_r;
  logic [31:0]            sim_report_r;
  logic                   sim_done_r;
  logic                   sim_success_r;
  logic                   timed_out_r;
  logic [31:0]            idle_r;
  logic                   have_prev_r;
  logic [COUNT_WIDTH-1:0] last_count_r;

  logic                   accept_s;
  logic [15:0]            new_count_s;
  logic                   finish_s;
  logic                   timeout_s;
  logic [1:0]             err_inc_s;

  // Saturating add of this cycle's error contributions.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Handshake, termination and per-sample error decode.
  always_comb begin
    accept_s    = s_valid && s_ready_r && (state_r == ST_RUN);
    new_count_s = sample_count_r + 16'd1;
    timeout_s   = (state_r == ST_RUN) && !accept_s && (idle_r == TIMEOUT_M1_C);
    finish_s    = timeout_s || (accept_s && (s_last || (new_count_s == EXPECTED_C)));
    err_inc_s   = 2'd0;
    if (accept_s) begin
      err_inc_s = {1'b0, (s_event == {EVENT_WIDTH{1'b0}})}
                + {1'b0, (have_prev_r && (s_count < last_count_r))}
                + {1'b0, (s_last && (new_count_s < EXPECTED_C))};
    end else if (timeout_s) begin
      err_inc_s = 2'd1;
    end else begin
      err_inc_s = 2'd0;
    end
  end

  // Run / summary / done sequencing with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_RUN;
      s_ready_r      <= 1'b0;
      sample_count_r <= 16'd0;
      error_count_r  <= 16'd0;
      sim_report_r   <= 32'd0;
      sim_done_r     <= 1'b0;
      sim_success_r  <= 1'b0;
      timed_out_r    <= 1'b0;
      idle_r         <= 32'd0;
      have_prev_r    <= 1'b0;
      last_count_r   <= {COUNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (accept_s) begin
            sample_count_r <= new_count_s;
            sim_report_r   <= 32'(s_count);
            last_count_r   <= s_count;
            have_prev_r    <= 1'b1;
            idle_r         <= 32'd0;
          end else begin
            idle_r <= idle_r + 32'd1;
          end
          error_count_r <= sat_add(error_count_r, err_inc_s);
          if (timeout_s) begin
            timed_out_r <= 1'b1;
          end
          if (finish_s) begin
            state_r   <= ST_SUMMARY;
            s_ready_r <= 1'b0;
          end else begin
            s_ready_r <= 1'b1;
          end
        end
        ST_SUMMARY: begin
          sim_report_r <= {error_count_r, sample_count_r};
          s_ready_r    <= 1'b0;
          state_r      <= ST_DONE;
        end
        ST_DONE: begin
          s_ready_r     <= 1'b0;
          sim_done_r    <= 1'b1;
          sim_success_r <= (error_count_r == 16'd0) && (sample_count_r == EXPECTED_C)
                           && !timed_out_r;
        end
        default: begin
          state_r   <= ST_RUN;
          s_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready      = s_ready_r;
  assign sample_count = sample_count_r;
  assign error_count  = error_count_r;
  assign sim_report   = sim_report_r;
  assign sim_done     = sim_done_r;
  assign sim_success  = sim_success_r;

endmodule

// File: tb/tb_perf_sample_checker.sv
// Bench for perf_sample_checker: directed table of runs plus randomized runs,
// checked every cycle against a run-level reference model.
module tb_perf_sample_checker;

  localparam int EXP = 16;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_event = 8'd0;
  logic [31:0] s_count = 32'd0;
  logic        s_last = 1'b0;
  logic [15:0] sample_count;
  logic [15:0] error_count;
  logic [31:0] sim_report;
  logic        sim_done;
  logic        sim_success;

  perf_sample_checker #(
    .EVENT_WIDTH(8), .COUNT_WIDTH(32), .EXPECTED_SAMPLES(EXP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_event(s_event), .s_count(s_count), .s_last(s_last),
    .sample_count(sample_count), .error_count(error_count),
    .sim_report(sim_report), .sim_done(sim_done), .sim_success(sim_success)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ev;
    logic [31:0] cnt;
    bit          last;
    int          gap;
  } samp_t;

  typedef struct {
    string       name;
    int          kind;
    int          exp_err;
    int          exp_cnt;
    logic [31:0] exp_sum;
    bit          exp_succ;
    int          exp_done;
  } dir_t;

  samp_t       sq[$];
  int          checks = 0;
  int          errors = 0;
  int          r_err, r_cnt, r_done_edge;
  logic [31:0] r_sum;
  bit          r_succ, r_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string name);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    check({name, " rst ready"}, s_ready, 0);
    check({name, " rst cnt"}, sample_count, 0);
    check({name, " rst err"}, error_count, 0);
    check({name, " rst report"}, sim_report, 0);
    check({name, " rst done"}, sim_done, 0);
    check({name, " rst succ"}, sim_success, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reset, then drive sq; abort >= 0 stops the run after that many acceptances.
  task automatic run(input string name, input int max_edges, input int abort);
    int          m_n = 0, m_err = 0, m_last_acc = -1, m_term = -1, idx = 0, gap_left;
    bit          m_hp = 0, m_to = 0, ready_b, acc, edone;
    logic [31:0] m_lastc = 32'd0, m_report = 32'd0, e_report;
    do_reset(name);
    gap_left    = (sq.size() > 0) ? sq[0].gap : 0;
    r_done_edge = -1;
    for (int e = 0; e < max_edges; e++) begin
      if (idx < sq.size() && gap_left == 0) begin
        s_valid = 1'b1;
        s_event = sq[idx].ev;
        s_count = sq[idx].cnt;
        s_last  = sq[idx].last;
      end else begin
        s_valid = 1'b0;
        s_event = 8'($urandom);
        s_count = $urandom;
        s_last  = 1'($urandom);
      end
      ready_b = (e >= 1) && (m_term < 0);
      acc     = ready_b && s_valid;
      @(posedge clk);
      #1;
      if (m_term < 0) begin
        if (acc) begin
          int inc;
          inc = int'(s_event == 8'd0) + int'(m_hp && (s_count < m_lastc))
              + int'(s_last && (m_n + 1 < EXP));
          m_n++;
          m_err      = (m_err + inc > 65535) ? 65535 : m_err + inc;
          m_report   = s_count;
          m_lastc    = s_count;
          m_hp       = 1;
          m_last_acc = e;
          if (s_last || m_n == EXP) m_term = e;
        end else if (e - m_last_acc == TMO) begin
          m_to   = 1;
          m_err  = (m_err + 1 > 65535) ? 65535 : m_err + 1;
          m_term = e;
        end
      end
      if (acc) begin
        idx++;
        gap_left = (idx < sq.size()) ? sq[idx].gap : 0;
      end else if (!s_valid && gap_left > 0) begin
        gap_left--;
      end
      edone    = (m_term >= 0) && (e >= m_term + 2);
      e_report = ((m_term >= 0) && (e >= m_term + 1)) ? {16'(m_err), 16'(m_n)} : m_report;
      check($sformatf("%s e%0d ready", name, e), s_ready, (m_term < 0) || (e < m_term));
      check($sformatf("%s e%0d cnt", name, e), sample_count, m_n);
      check($sformatf("%s e%0d err", name, e), error_count, m_err);
      check($sformatf("%s e%0d report", name, e), sim_report, e_report);
      check($sformatf("%s e%0d done", name, e), sim_done, edone);
      check($sformatf("%s e%0d succ", name, e), sim_success,
            edone && m_err == 0 && m_n == EXP && !m_to);
      if (sim_done && r_done_edge < 0) r_done_edge = e;
      if (abort >= 0 && m_n == abort) break;
      if (m_term >= 0 && e >= m_term + 3) break;
    end
    if (abort < 0 && !(m_term >= 0 && r_done_edge >= 0)) begin
      errors++;
      $display("FAIL %s bound: run did not finish in %0d edges", name, max_edges);
    end
    s_valid = 1'b0;
    r_err   = error_count;
    r_cnt   = sample_count;
    r_sum   = sim_report;
    r_succ  = sim_success;
    r_done  = sim_done;
  endtask

  task automatic build_mono(input int n, input bit last_on_final);
    sq.delete();
    for (int i = 0; i < n; i++) begin
      samp_t s;
      s.ev   = 8'd1;
      s.cnt  = 32'(10 * i);
      s.last = last_on_final && (i == n - 1);
      s.gap  = 0;
      sq.push_back(s);
    end
  endtask

  task automatic build_kind(input int kind);
    case (kind)
      0: build_mono(16, 1);
      1: begin build_mono(16, 1); sq[6].cnt = 32'd40; end
      2: begin build_mono(3, 1); sq[1].ev = 8'd0; end
      3: sq.delete();
      4: build_mono(17, 0);
      5: begin build_mono(16, 1); sq[3].gap = TMO - 1; end
      6: begin build_mono(6, 0); sq[5].gap = TMO; end
      default: sq.delete();
    endcase
  endtask

  task automatic build_random();
    int          n, r;
    logic [31:0] c = 32'd0;
    sq.delete();
    n = $urandom_range(1, 20);
    for (int i = 0; i < n; i++) begin
      samp_t s;
      r     = $urandom_range(0, 29);
      s.gap = (r < 20) ? 0 : (r < 27) ? $urandom_range(1, 3) : (r == 27) ? TMO - 1 :
              (r == 28) ? TMO : 0;
      s.ev  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0 && c > 32'd5) c = c - 32'($urandom_range(1, 5));
      else c = c + 32'($urandom_range(0, 20));
      s.cnt  = c;
      s.last = ($urandom_range(0, 11) == 0) || (i == n - 1 && $urandom_range(0, 1) == 1);
      sq.push_back(s);
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_t tbl[7];
    tbl[0] = '{"mono",     0, 0, 16, 32'h0000_0010, 1'b1, 18};
    tbl[1] = '{"decr",     1, 1, 16, 32'h0001_0010, 1'b0, 18};
    tbl[2] = '{"zeroshort",2, 2, 3,  32'h0002_0003, 1'b0, 5};
    tbl[3] = '{"timeout",  3, 1, 0,  32'h0001_0000, 1'b0, TMO + 1};
    tbl[4] = '{"overrun",  4, 0, 16, 32'h0000_0010, 1'b1, 18};
    tbl[5] = '{"stall99",  5, 0, 16, 32'h0000_0010, 1'b1, 117};
    tbl[6] = '{"stall100", 6, 1, 5,  32'h0001_0005, 1'b0, 107};
    #2;
    for (int t = 0; t < 7; t++) begin
      build_kind(tbl[t].kind);
      run(tbl[t].name, 400, -1);
      check({tbl[t].name, " final err"}, r_err, tbl[t].exp_err);
      check({tbl[t].name, " final cnt"}, r_cnt, tbl[t].exp_cnt);
      check({tbl[t].name, " summary"}, r_sum, tbl[t].exp_sum);
      check({tbl[t].name, " done"}, r_done, 1);
      check({tbl[t].name, " success"}, r_succ, tbl[t].exp_succ);
      check({tbl[t].name, " done edge"}, r_done_edge, tbl[t].exp_done);
    end

    // Reset in the middle of a run, then a clean run must pass.
    build_mono(16, 1);
    run("midrun", 400, 7);
    check("midrun cnt before reset", sample_count, 7);
    build_mono(16, 1);
    run("after_reset", 400, -1);
    check("after_reset success", r_succ, 1);
    check("after_reset cnt", r_cnt, 16);

    // Reset while in DONE.
    do_reset("in_done");

    for (int k = 0; k < 12; k++) begin
      build_random();
      run($sformatf("rand%0d", k), 2600, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
